// File: rtl/fifo_param_pkg.sv
// Shared types and defaults for the parameterised FIFO.
package fifo_param_pkg;

    parameter int unsigned DefDataWidth = 32;
    parameter int unsigned DefDepth     = 8;

    // Per-cycle handshake outcome, registered and decoded to ack/err a cycle later.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StWrErr = 3'd2,
        StRead  = 3'd3,
        StRdErr = 3'd4,
        StRw    = 3'd5
    } fifo_state_e;

endpackage

// File: rtl/regbank_param.sv
// DEPTH x DATA_WIDTH register bank with one-hot write enables and a shared write bus.
module regbank_param
    import fifo_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [DEPTH-1:0]                    en,
    input  logic [DATA_WIDTH-1:0]               d_in,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]    q
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        // Each entry loads the shared bus when its enable bit is set; reset clears it.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q[i] <= '0;
            end else if (en[i]) begin
                q[i] <= d_in;
            end
        end
    end

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO: pointers, occupancy count, read mux and handshake FSM.
// Optional sticky overflow/underflow flags are built only when FIFO_STICKY_ERR_EN is defined.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  full,
    output logic                  empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [AW:0]           data_count,
    output logic                  ovf_sticky,
    output logic                  udf_sticky
);

    logic [AW-1:0]                   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                   rd_ptr_q, rd_ptr_d;
    logic [AW:0]                     count_q, count_d;
    logic [DATA_WIDTH-1:0]           d_out_q, d_out_d;
    logic [DEPTH-1:0]                wr_sel;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] bank;
    fifo_state_e                     state_q, state_d;
    // Pop rejected in the same cycle a push was accepted (empty, both requested).
    logic                            rd_rej_q, rd_rej_d;
    logic                            wr_ok, rd_ok;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign data_count = count_q;
    assign d_out      = d_out_q;

    // A pop frees a slot, so a push into a full FIFO still lands when paired with a pop.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    // One-hot write enable decoded from the write pointer.
    always_comb begin
        wr_sel = '0;
        if (wr_ok) begin
            wr_sel[wr_ptr_q] = 1'b1;
        end
    end

    regbank_param #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (wr_sel),
        .d_in    (d_in),
        .q       (bank)
    );

    // Pointer, count and read-data next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        d_out_d  = d_out_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            d_out_d  = bank[rd_ptr_q];
        end
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            d_out_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            d_out_q  <= d_out_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            rd_rej_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_rej_q <= rd_rej_d;
        end
    end

    // FSM next state: classify this cycle's requests against the occupancy flags.
    always_comb begin
        rd_rej_d = wr_ok && rd_en && !rd_ok;
        if (wr_ok && rd_ok) begin
            state_d = StRw;
        end else if (wr_ok) begin
            state_d = StWrite;
        end else if (rd_ok) begin
            state_d = StRead;
        end else if (wr_en) begin
            state_d = StWrErr;
        end else if (rd_en) begin
            state_d = StRdErr;
        end else begin
            state_d = StIdle;
        end
    end

    // FSM outputs: decode the registered outcome into ack/err strobes.
    always_comb begin
        wr_ack = (state_q == StWrite) || (state_q == StRw);
        wr_err = (state_q == StWrErr);
        rd_ack = (state_q == StRead) || (state_q == StRw);
        rd_err = (state_q == StRdErr) || rd_rej_q;
    end

`ifdef FIFO_STICKY_ERR_EN
    logic ovf_q, udf_q;

    // Sticky flags rise together with the err strobe and hold until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q || (state_d == StWrErr);
            udf_q <= udf_q || (state_d == StRdErr) || rd_rej_d;
        end
    end

    assign ovf_sticky = ovf_q;
    assign udf_sticky = udf_q;
`else
    assign ovf_sticky = 1'b0;
    assign udf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (DATA_WIDTH=32, DEPTH=8).
module tb_fifo_param;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 8;
`ifdef FIFO_STICKY_ERR_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          full, empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;
    logic [3:0]    data_count;
    logic          ovf_sticky, udf_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .d_in       (d_in),
        .d_out      (d_out),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .data_count (data_count),
        .ovf_sticky (ovf_sticky),
        .udf_sticky (udf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
        wr_en = w;
        rd_en = r;
        d_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_hs(input string tag, input logic wa, input logic we,
                            input logic ra, input logic re, input logic [3:0] cnt);
        check({tag, ".wr_ack"}, 64'(wr_ack), 64'(wa));
        check({tag, ".wr_err"}, 64'(wr_err), 64'(we));
        check({tag, ".rd_ack"}, 64'(rd_ack), 64'(ra));
        check({tag, ".rd_err"}, 64'(rd_err), 64'(re));
        check({tag, ".count"},  64'(data_count), 64'(cnt));
    endtask

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        d_in    = '0;
        #12;
        reset_n = 1'b1;

        // Reset state
        check("rst.empty", 64'(empty), 64'd1);
        check("rst.full",  64'(full),  64'd0);
        check("rst.d_out", 64'(d_out), 64'd0);
        check_hs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("rst.ovf", 64'(ovf_sticky), 64'd0);
        check("rst.udf", 64'(udf_sticky), 64'd0);

        // Pop from empty
        cycle(1'b0, 1'b1, '0);
        check_hs("udf", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("udf.empty", 64'(empty), 64'd1);
        check("udf.d_out", 64'(d_out), 64'd0);
        check("udf.sticky", 64'(udf_sticky), 64'(STICKY));
        cycle(1'b0, 1'b0, '0);
        check_hs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("idle.udf_hold", 64'(udf_sticky), 64'(STICKY));

        // Fill with 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, DW'(8'h11 * (i + 1)));
            check_hs($sformatf("push%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 4'(i + 1));
            check($sformatf("push%0d.full", i), 64'(full), 64'(i == 7));
        end
        cycle(1'b1, 1'b0, 32'h99);
        check_hs("ovf", 1'b0, 1'b1, 1'b0, 1'b0, 4'd8);
        check("ovf.full", 64'(full), 64'd1);
        check("ovf.sticky", 64'(ovf_sticky), 64'(STICKY));

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, '0);
            check_hs($sformatf("pop%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 4'(7 - i));
            check($sformatf("pop%0d.d_out", i), 64'(d_out), 64'(8'h11 * (i + 1)));
        end
        check("drain.empty", 64'(empty), 64'd1);
        cycle(1'b0, 1'b0, '0);
        check("hold.d_out", 64'(d_out), 64'h88);

        // Pointer wrap: push 5 / pop 5 / push 6 / pop 6
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, DW'(32'hA0 + i));
            check_hs($sformatf("wpa%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 4'(i + 1));
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("wra%0d.d_out", i), 64'(d_out), 64'(32'hA0 + i));
            check_hs($sformatf("wra%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 4'(4 - i));
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, DW'(32'hB0 + i));
            check_hs($sformatf("wpb%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 4'(i + 1));
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("wrb%0d.d_out", i), 64'(d_out), 64'(32'hB0 + i));
            check_hs($sformatf("wrb%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 4'(5 - i));
        end

        // Simultaneous push/pop when empty: push wins, pop rejected
        cycle(1'b1, 1'b1, 32'h55);
        check_hs("rw_empty", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        check("rw_empty.d_out", 64'(d_out), 64'hB5);
        for (int i = 1; i < 8; i++) begin
            cycle(1'b1, 1'b0, DW'(32'h55 + i));
        end
        check("fill2.full", 64'(full), 64'd1);
        // Simultaneous push/pop when full: both accepted
        cycle(1'b1, 1'b1, 32'h5D);
        check_hs("rw_full", 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
        check("rw_full.d_out", 64'(d_out), 64'h55);
        check("rw_full.full", 64'(full), 64'd1);

        // Pop 4 to reach count 4, then reset mid-burst
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("pre_rst%0d.d_out", i), 64'(d_out), 64'(32'h56 + i));
        end
        check("pre_rst.count", 64'(data_count), 64'd4);
        wr_en = 1'b1;
        d_in  = 32'hEE;
        #3;
        reset_n = 1'b0;
        #1;
        check_hs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("async_rst.empty", 64'(empty), 64'd1);
        check("async_rst.full",  64'(full),  64'd0);
        check("async_rst.d_out", 64'(d_out), 64'd0);
        check("async_rst.ovf",   64'(ovf_sticky), 64'd0);
        check("async_rst.udf",   64'(udf_sticky), 64'd0);
        wr_en = 1'b0;
        #2;
        reset_n = 1'b1;
        cycle(1'b0, 1'b1, '0);
        check_hs("post_rst", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("post_rst.d_out", 64'(d_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data word width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of entries (a power of two, 2..256); AW = log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: push request.
REQ-006 The block SHALL have port rd_en, input, 1 bit: pop request.
REQ-007 The block SHALL have port d_in, input, DATA_WIDTH bits: push data.
REQ-008 The block SHALL have port d_out, output, DATA_WIDTH bits: registered pop data.
REQ-009 The block SHALL have ports full and empty, outputs, 1 bit each: occupancy flags.
REQ-010 The block SHALL have ports wr_ack, wr_err, rd_ack and rd_err, outputs, 1 bit each: registered per-cycle handshake results.
REQ-011 The block SHALL have port data_count, output, AW+1 bits: current occupancy.
REQ-012 The block SHALL have ports ovf_sticky and udf_sticky, outputs, 1 bit each: sticky error flags (see Configuration).

Function
REQ-013 Entries SHALL be held in a DEPTH x DATA_WIDTH register bank; each entry SHALL have a one-hot write enable decoded from the write pointer wr_ptr (AW bits).
REQ-014 A push SHALL be accepted when wr_en=1 and (full=0 or a pop is accepted in the same cycle); d_in is stored at wr_ptr, wr_ptr increments modulo DEPTH, and wr_ack=1 on the next cycle.
REQ-015 A pop SHALL be accepted when rd_en=1 and empty=0; d_out takes the entry at rd_ptr on the next edge, rd_ptr increments modulo DEPTH, and rd_ack=1 (read latency 1 cycle).
REQ-016 A rejected push SHALL set wr_err=1 for one cycle, leaving the storage, pointers and count unchanged.
REQ-017 A rejected pop SHALL set rd_err=1 for one cycle; d_out, pointers and count SHALL hold.
REQ-018 Simultaneous push and pop while empty SHALL accept the push and reject the pop (count 0->1).
REQ-019 Simultaneous push and pop while full SHALL accept both (count stays DEPTH, data_count unchanged).
REQ-020 A control FSM SHALL have states IDLE, WRITE, WR_ERR, READ, RD_ERR and RW, selected each cycle from {wr_en, rd_en, full, empty}; the state registered in a cycle SHALL drive the ack/err outputs on the following cycle.
REQ-021 The ack and err outputs SHALL be 0 when the corresponding request is absent.
REQ-022 full SHALL equal (data_count==DEPTH) and empty SHALL equal (data_count==0), both derived from the registered count.
REQ-023 d_out SHALL hold its value on all cycles without an accepted pop.

Reset
REQ-024 On reset_n=0 the block SHALL asynchronously clear wr_ptr, rd_ptr, data_count, d_out, all ack/err outputs and both sticky flags, and set the state to IDLE; empty=1 and full=0.
REQ-025 On reset_n=0 the block SHALL clear all bank entries to 0; a reset mid-transfer SHALL discard all contents.

Configuration
REQ-026 With macro FIFO_STICKY_ERR_EN defined, ovf_sticky SHALL set on any wr_err and udf_sticky on any rd_err, and each SHALL remain set until reset.
REQ-027 Without FIFO_STICKY_ERR_EN, ovf_sticky and udf_sticky SHALL be tied to 0 and no sticky logic SHALL exist.

Structure
REQ-028 A package fifo_param_pkg SHALL hold the FSM state encoding typedef (IDLE, WRITE, WR_ERR, READ, RD_ERR, RW) and the default DATA_WIDTH/DEPTH constants.
REQ-029 Storage SHALL be one sub-module, regbank_param: a parametrised DEPTH-entry register bank with a one-hot en vector, a shared d_in, async active-low reset, and all entries as outputs; fifo_param SHALL hold the FSM, pointers, count and read mux.

Verification
REQ-030 Reset, then rd_en=1 for 1 cycle -> rd_err=1, empty=1, data_count=0, d_out=0, udf_sticky=1 (macro defined).
REQ-031 Push 8 words 0x11..0x88 (DEPTH=8) -> wr_ack each cycle, full=1 after the 8th; a 9th push -> wr_err=1, count stays 8.
REQ-032 Pop 8 times -> d_out=0x11..0x88 in order, one cycle after each rd_en; empty=1 after the last pop.
REQ-033 Pointer wrap: push 5, pop 5, push 6, pop 6 -> data in order, pointers wrap past 7 to 0, no errors.
REQ-034 Simultaneous wr_en=rd_en=1 when empty -> wr_ack=1, rd_err=1, count=1; the same when full -> wr_ack=1, rd_ack=1, count=8.
REQ-035 Assert reset_n=0 asynchronously mid-burst at count=4 -> all outputs clear immediately; a following pop -> rd_err=1.
